fetch_resp_buffer: RTL and testbench

//  Receiving end of the instruction-fetch interface. Pairs each fetch request (PC issued to inst SRAM

---
 rtl/fetch_resp_buffer_if.sv | 34 +++
 rtl/fetch_resp_buffer.sv | 104 ++++++++++
 tb/tb_fetch_resp_buffer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fetch_resp_buffer_if.sv
//------------------------------------------------------------------------------
// fetch_resp_buffer_if : IF-side request/response and decode-side handshake
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_resp_buffer_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  logic              fs_req_valid;
  logic [PC_W-1:0]   fs_req_pc;
  logic              fs_allowin;
  logic [INST_W-1:0] inst_sram_rdata;
  logic              flush;
  logic              ds_valid;
  logic              ds_ready;
  logic [PC_W-1:0]   ds_pc;
  logic [INST_W-1:0] ds_inst;

  // master: the surrounding pipeline (IF unit, SRAM, ID unit)
  modport master (
    output fs_req_valid, fs_req_pc, inst_sram_rdata, flush, ds_ready,
    input  fs_allowin, ds_valid, ds_pc, ds_inst
  );

  // slave: the response buffer itself
  modport slave (
    input  fs_req_valid, fs_req_pc, inst_sram_rdata, flush, ds_ready,
    output fs_allowin, ds_valid, ds_pc, ds_inst
  );
endinterface

`default_nettype wire

// File: rtl/fetch_resp_buffer.sv
//------------------------------------------------------------------------------
// fetch_resp_buffer : pairs fetch PCs with next-cycle SRAM data, queues to decode
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_resp_buffer #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             reset,
  fetch_resp_buffer_if.slave    bus,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              resp_pending_q, resp_pending_d;
  logic [PC_W-1:0]   resp_pc_q, resp_pc_d;
  logic [PC_W-1:0]   mem_pc_q   [DEPTH];
  logic [PC_W-1:0]   mem_pc_d   [DEPTH];
  logic [INST_W-1:0] mem_inst_q [DEPTH];
  logic [INST_W-1:0] mem_inst_d [DEPTH];

  logic              req_fire;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    occupancy;

  // Occupancy reserves a slot for the in-flight response, so a push never hits a full FIFO.
  assign occupancy      = {1'b0, count_q} + {{CNT_W{1'b0}}, resp_pending_q};
  assign bus.fs_allowin = ~reset & (occupancy < (CNT_W+1)'(DEPTH));
  assign bus.ds_valid   = (count_q != '0);
  assign bus.ds_pc      = bus.ds_valid ? mem_pc_q[rd_ptr_q]   : '0;
  assign bus.ds_inst    = bus.ds_valid ? mem_inst_q[rd_ptr_q] : '0;
  assign count          = count_q;

  assign req_fire = bus.fs_req_valid & bus.fs_allowin & ~bus.flush;
  assign push     = resp_pending_q & ~bus.flush;
  assign pop      = bus.ds_valid & bus.ds_ready & ~bus.flush;

  always_comb begin
    count_d        = count_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    resp_pending_d = req_fire;
    resp_pc_d      = req_fire ? bus.fs_req_pc : resp_pc_q;
    mem_pc_d       = mem_pc_q;
    mem_inst_d     = mem_inst_q;

    if (push) begin
      mem_pc_d[wr_ptr_q]   = resp_pc_q;
      mem_inst_d[wr_ptr_q] = bus.inst_sram_rdata;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A taken branch makes everything older wrong-path, including this cycle's response.
    if (bus.flush) begin
      count_d        = '0;
      rd_ptr_d       = '0;
      wr_ptr_d       = '0;
      resp_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q        <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      resp_pending_q <= 1'b0;
      resp_pc_q      <= '0;
    end else begin
      count_q        <= count_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      resp_pending_q <= resp_pending_d;
      resp_pc_q      <= resp_pc_d;
    end
  end

  // Storage needs no reset: entries are only observable while count says they are valid.
  always_ff @(posedge clk) begin
    mem_pc_q   <= mem_pc_d;
    mem_inst_q <= mem_inst_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_resp_buffer.sv
//------------------------------------------------------------------------------
// tb_fetch_resp_buffer : randomized + directed scoreboard bench for fetch_resp_buffer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_resp_buffer;

  localparam int DEPTH = 4;
  localparam logic [31:0] K = 32'hA5A5A5A5;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] count;

  fetch_resp_buffer_if #(.PC_W(32), .INST_W(32)) bus ();

  fetch_resp_buffer #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a queue of {pc, inst} pairs plus at most one outstanding fetch.
  logic [63:0] mq[$];
  bit          mpend = 0;
  logic [31:0] mpc   = '0;

  always @(posedge clk) begin
    bit accept;
    if (reset || bus.flush) begin
      mq.delete();
      mpend = 0;
    end else begin
      accept = bus.fs_req_valid && ((mq.size() + int'(mpend)) < DEPTH);
      if (mq.size() != 0 && bus.ds_ready) void'(mq.pop_front());
      if (mpend) mq.push_back({mpc, bus.inst_sram_rdata});
      mpend = accept;
      mpc   = bus.fs_req_pc;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the model between clock edges.
  int delivered = 0;
  always @(negedge clk) begin
    bit exp_allow;
    exp_allow = !reset && ((mq.size() + int'(mpend)) < DEPTH);
    chk("fs_allowin", 64'(bus.fs_allowin), 64'(exp_allow));
    chk("count", 64'(count), 64'(mq.size()));
    chk("ds_valid", 64'(bus.ds_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("ds_pc", 64'(bus.ds_pc), 64'(mq[0][63:32]));
      chk("ds_inst", 64'(bus.ds_inst), 64'(mq[0][31:0]));
      if (bus.ds_ready && !bus.flush && !reset) delivered++;
    end else begin
      chk("ds_pc_idle", 64'(bus.ds_pc), 64'd0);
      chk("ds_inst_idle", 64'(bus.ds_inst), 64'd0);
    end
  end

  logic [31:0] last_pc = '0;

  // One clock of stimulus; rdata always answers the PC offered the previous cycle.
  task automatic cyc(input bit v, input logic [31:0] pc, input bit rdy, input bit fl);
    bus.inst_sram_rdata = last_pc ^ K;
    bus.fs_req_valid    = v;
    bus.fs_req_pc       = pc;
    bus.ds_ready        = rdy;
    bus.flush           = fl;
    last_pc             = pc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    bit          pat[5];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    reset = 1'b1;
    bus.fs_req_valid = 0; bus.fs_req_pc = '0; bus.inst_sram_rdata = '0;
    bus.flush = 0; bus.ds_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Stream at full rate
    pc = 32'h1c000000;
    for (int i = 0; i < 12; i++) begin cyc(1, pc, 1, 0); pc += 4; end
    for (int i = 0; i < 4; i++) cyc(0, pc, 1, 0);

    // Stall until full, then drain
    for (int i = 0; i < 8; i++) begin cyc(1, pc, 0, 0); pc += 4; end
    for (int i = 0; i < 8; i++) cyc(0, pc, 1, 0);

    // Flush a full buffer, then a single correct-path fetch
    for (int i = 0; i < 6; i++) begin cyc(1, pc, 0, 0); pc += 4; end
    cyc(0, pc, 0, 0);
    cyc(0, pc, 0, 1);
    cyc(1, 32'h1c000100, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, pc, 0, 0);
    cyc(0, pc, 1, 0);
    cyc(0, pc, 1, 0);

    // Flush while a response is in flight, with a new fetch offered in the flush cycle
    cyc(1, 32'h1c000200, 1, 0);
    cyc(1, 32'h1c000204, 1, 1);
    for (int i = 0; i < 4; i++) cyc(0, pc, 1, 0);

    // 20 fetches with decode ready pattern 1,0,1,1,0
    begin
      int issued = 0;
      int c = 0;
      pc = 32'h1c001000;
      while (issued < 20 && c < 200) begin
        bit take;
        take = bus.fs_allowin;
        cyc(1, pc, pat[c % 5], 0);
        if (take) begin issued++; pc += 4; end
        c++;
      end
      for (int i = 0; i < 12; i++) cyc(0, pc, pat[i % 5], 0);
    end

    // Reset mid-operation: three entries queued and one response in flight
    for (int i = 0; i < 3; i++) begin cyc(1, pc, 0, 0); pc += 4; end
    cyc(1, pc, 0, 0); pc += 4;
    reset = 1'b1;
    cyc(0, pc, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, pc, 1, 0);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      cyc(bit'($urandom_range(0, 3) != 0), $urandom & 32'hFFFFFFFC,
          bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 19) == 0));
    end

    // Drain with a bounded budget
    for (int i = 0; i < 10; i++) cyc(0, pc, 1, 0);
    chk("drained", 64'(mq.size()), 64'd0);
    if (delivered < 30) begin
      n_bad++;
      $display("FAIL delivered: got %0d entries, expected at least 30", delivered);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
